hd_memory_write_ctrl: RTL and testbench
=======================================

# hd_memory_write_ctrl

Write sequencer and arbiter in front of the HD-Memory. Shares the memory write port between the encoder (full hypervector rows) and the host configuration path (single 32-bit words). Issues each encoder row either as one row-wide write (`RowMode`) or as a burst of word writes (`WordMode`) according to a configuration input. Sits between the encoder/host bus and the HD-Memory macro; all memory-side outputs are registered.

## Interface
- `DIMENSION`, 512: hypervector width in bits.
- `WORD_WIDTH`, 32: word width; `DIMENSION % WORD_WIDTH == 0`.
- `NUM_ROWS`, 16: memory rows; `RA = $clog2(NUM_ROWS)`, `NUM_WORDS = DIMENSION/WORD_WIDTH`, `WA = $clog2(NUM_WORDS)`.
- `clk_i` in 1: single clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `cfg_mode_i` in `write_mode_t`: write mode for encoder rows, sampled on row accept.
- `row_valid_i` / `row_ready_o` in/out 1: encoder handshake.
- `row_addr_i` in RA: target row.
- `row_data_i` in DIMENSION: row payload.
- `host_valid_i` / `host_ready_o` in/out 1: host handshake.
- `host_row_i` in RA; `host_word_i` in WA: target row and word.
- `host_data_i` in WORD_WIDTH: word payload.
- `mem_we_o` out 1: write strobe.
- `mem_mode_o` out `write_mode_t`: mode of the current write.
- `mem_row_o` out RA; `mem_word_o` out WA: write address.
- `mem_wdata_o` out DIMENSION: full row in `RowMode`; word in bits `[WORD_WIDTH-1:0]` with upper bits zero in `WordMode`.
- `busy_o` out 1: state != IDLE.
- `row_done_o` out 1: one-cycle pulse on the last memory write of an encoder row.

## Operation
- States: IDLE, ROW_WR, WORD_BURST, HOST_WR.
- `row_ready_o` and `host_ready_o` are high only in IDLE, and only for the requester the arbiter grants. At most one of them is high in any cycle.
- Arbitration in IDLE:
  - Only one valid: that requester is granted.
  - Both valid: round-robin. The requester not served last is granted. The `last_grant` flag updates on each accept.
- Row accept with `cfg_mode_i == RowMode`: latch address and data, go to ROW_WR.
- Row accept with `cfg_mode_i == WordMode`: latch address and data, clear the word counter, go to WORD_BURST.
- Host accept: latch row, word and data, go to HOST_WR. Host writes are always `WordMode`.
- ROW_WR: one row write, then IDLE.
- WORD_BURST:
  - Writes word `k = 0..NUM_WORDS-1` of the latched row, one word per cycle, with data `row[k*WORD_WIDTH +: WORD_WIDTH]`.
  - After word `NUM_WORDS-1`, go to IDLE. The counter does not wrap.
- HOST_WR: one word write, then IDLE.
- `cfg_mode_i` changes during a burst are ignored until the next accept.
- No requests are accepted while busy; bursts are never interleaved with host writes.
- Reset (any state, including mid-burst):
  - The burst is aborted and the state returns to IDLE.
  - All outputs go to 0, with `mem_mode_o = WordMode`.
  - `last_grant` resets so the encoder wins the first tie.

## Timing
- Accept at edge T gives `mem_we_o` high in the cycle after T, registered from state.
- `RowMode`:
  - One write cycle, with `row_done_o` in the same cycle.
  - IDLE and ready again one cycle later.
  - Throughput: one row per 2 cycles.
- `WordMode` row:
  - `mem_we_o` high for NUM_WORDS consecutive cycles.
  - `row_done_o` coincides with word NUM_WORDS-1.
  - Next accept is possible NUM_WORDS+1 cycles after the previous one.
- Host word: one write cycle; next accept possible 2 cycles later.
- When `mem_we_o` is low, `mem_row_o`, `mem_word_o` and `mem_wdata_o` hold their last value and are don't-care for the memory.

## Structure
- `pkg_hd_memory`:
  - Keeps the existing `write_mode_t` (`WordMode`/`RowMode`).
  - Adds the enum `hd_mem_ctrl_state_t` {IDLE, ROW_WR, WORD_BURST, HOST_WR}.
- Sub-module `hd_mem_rr_arbiter`: 2-input round-robin arbiter holding the `last_grant` register, with grant gated by an `enable` input (= IDLE).
- Word counter, latches and FSM are local to `hd_memory_write_ctrl`.

## Test plan
All scenarios use DIMENSION=512, WORD_WIDTH=32, NUM_ROWS=16.
- RowMode row: row 5, data `{16{32'hA5A5_0000 + k}}` -> one write with `mem_mode_o=RowMode`, `mem_row_o=5`, full data, `row_done_o` in the same cycle, ready 2 cycles after accept.
- WordMode row: row 3, word `k` = `32'h100 + k` -> 16 consecutive writes with `mem_word_o` 0..15, `mem_wdata_o[31:0]` = `0x100..0x10F`, upper bits 0, `row_done_o` only on word 15.
- Simultaneous requests three times in a row -> grants in order encoder, host, encoder. A host request arriving mid-burst waits until the burst ends, then is written as row 2 word 7 data `0xDEADBEEF`.
- `cfg_mode_i` toggled to RowMode at burst word 4 -> burst continues in WordMode through word 15. The next row uses RowMode.
- `rst_i` asserted at burst word 6 -> the next cycle has `mem_we_o=0`, `busy_o=0`, no `row_done_o`. After release, the encoder wins a tie.
- Back-to-back host writes, valid held for 4 requests -> exactly 4 writes, one every 2 cycles, no lost or duplicated request.

Source files
------------

// File: rtl/hd_memory_write_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pkg_hd_memory
// Description : Shared types for the HD-Memory write path. These are the
//               write mode enum and the write-controller state enum.
// Revision    : 1.0 - initial release
// ============================================================================
package pkg_hd_memory;

    // Kind of memory write: a single word, or a full hypervector row.
    typedef enum logic [0:0] {
        WordMode = 1'b0,
        RowMode  = 1'b1
    } write_mode_t;

    // Write controller sequencing states.
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ROW_WR     = 2'd1,
        WORD_BURST = 2'd2,
        HOST_WR    = 2'd3
    } hd_mem_ctrl_state_t;

endpackage
`default_nettype wire

// File: rtl/hd_mem_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : hd_mem_rr_arbiter
// Description : Two-input round-robin arbiter (encoder row / host word).
//               A sole requester is granted. On a tie, the requester not
//               served last is granted. Grants appear only while enabled.
// Revision    : 1.0 - initial release
// ============================================================================
module hd_mem_rr_arbiter (
    input  logic clk,
    input  logic rst,
    input  logic i_enable,
    input  logic i_req_row,
    input  logic i_req_host,
    output logic o_gnt_row,
    output logic o_gnt_host
);

    // High when the host was the last requester served.
    logic r_last_host;

    assign o_gnt_row  = i_enable & i_req_row  & (~i_req_host | r_last_host);
    assign o_gnt_host = i_enable & i_req_host & (~i_req_row  | ~r_last_host);

    // Remember who was served last. Reset favours the encoder on the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_host <= 1'b1;
        end else if (o_gnt_row) begin
            r_last_host <= 1'b0;
        end else if (o_gnt_host) begin
            r_last_host <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/hd_memory_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hd_memory_write_ctrl
// Description : Write sequencer and arbiter for the HD-Memory write port.
//               Encoder rows are written either as one row-wide write or as
//               a burst of word writes. Host words are written singly. All
//               memory-side outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module hd_memory_write_ctrl
    import pkg_hd_memory::*;
#(
    parameter  int DIMENSION  = 512,
    parameter  int WORD_WIDTH = 32,
    parameter  int NUM_ROWS   = 16,
    localparam int RA         = $clog2(NUM_ROWS),
    localparam int NUM_WORDS  = DIMENSION / WORD_WIDTH,
    localparam int WA         = $clog2(NUM_WORDS)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  write_mode_t           cfg_mode_i,
    input  logic                  row_valid_i,
    output logic                  row_ready_o,
    input  logic [RA-1:0]         row_addr_i,
    input  logic [DIMENSION-1:0]  row_data_i,
    input  logic                  host_valid_i,
    output logic                  host_ready_o,
    input  logic [RA-1:0]         host_row_i,
    input  logic [WA-1:0]         host_word_i,
    input  logic [WORD_WIDTH-1:0] host_data_i,
    output logic                  mem_we_o,
    output write_mode_t           mem_mode_o,
    output logic [RA-1:0]         mem_row_o,
    output logic [WA-1:0]         mem_word_o,
    output logic [DIMENSION-1:0]  mem_wdata_o,
    output logic                  busy_o,
    output logic                  row_done_o
);

    localparam int          c_PAD       = DIMENSION - WORD_WIDTH;
    localparam logic [WA-1:0] c_LAST_WORD = WA'(NUM_WORDS - 1);

    hd_mem_ctrl_state_t     r_state;
    logic [DIMENSION-1:0]   r_row_data;
    logic [WA-1:0]          r_word_cnt;

    logic                   w_idle;
    logic                   w_gnt_row;
    logic                   w_gnt_host;
    logic [WA-1:0]          w_next_word;
    logic [WORD_WIDTH-1:0]  w_burst_word;

    assign w_idle       = (r_state == IDLE);
    assign w_next_word  = r_word_cnt + WA'(1);
    assign w_burst_word = r_row_data[int'(w_next_word) * WORD_WIDTH +: WORD_WIDTH];

    assign row_ready_o  = w_gnt_row;
    assign host_ready_o = w_gnt_host;
    assign busy_o       = ~w_idle;

    hd_mem_rr_arbiter u_arb (
        .clk        (clk_i),
        .rst        (rst_i),
        .i_enable   (w_idle),
        .i_req_row  (row_valid_i),
        .i_req_host (host_valid_i),
        .o_gnt_row  (w_gnt_row),
        .o_gnt_host (w_gnt_host)
    );

    // Sequencer: the accept edge already loads the first write, so mem_we_o
    // rises in the cycle right after the handshake.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_row_data  <= '0;
            r_word_cnt  <= '0;
            mem_we_o    <= 1'b0;
            mem_mode_o  <= WordMode;
            mem_row_o   <= '0;
            mem_word_o  <= '0;
            mem_wdata_o <= '0;
            row_done_o  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    mem_we_o   <= 1'b0;
                    row_done_o <= 1'b0;
                    if (w_gnt_row) begin
                        r_row_data <= row_data_i;
                        r_word_cnt <= '0;
                        mem_we_o   <= 1'b1;
                        mem_row_o  <= row_addr_i;
                        mem_word_o <= '0;
                        if (cfg_mode_i == RowMode) begin
                            r_state     <= ROW_WR;
                            mem_mode_o  <= RowMode;
                            mem_wdata_o <= row_data_i;
                            row_done_o  <= 1'b1;
                        end else begin
                            r_state     <= WORD_BURST;
                            mem_mode_o  <= WordMode;
                            mem_wdata_o <= {{c_PAD{1'b0}}, row_data_i[WORD_WIDTH-1:0]};
                        end
                    end else if (w_gnt_host) begin
                        r_state     <= HOST_WR;
                        mem_we_o    <= 1'b1;
                        mem_mode_o  <= WordMode;
                        mem_row_o   <= host_row_i;
                        mem_word_o  <= host_word_i;
                        mem_wdata_o <= {{c_PAD{1'b0}}, host_data_i};
                    end
                end
                ROW_WR, HOST_WR: begin
                    r_state    <= IDLE;
                    mem_we_o   <= 1'b0;
                    row_done_o <= 1'b0;
                end
                WORD_BURST: begin
                    if (r_word_cnt == c_LAST_WORD) begin
                        r_state    <= IDLE;
                        mem_we_o   <= 1'b0;
                        row_done_o <= 1'b0;
                    end else begin
                        r_word_cnt  <= w_next_word;
                        mem_word_o  <= w_next_word;
                        mem_wdata_o <= {{c_PAD{1'b0}}, w_burst_word};
                        row_done_o  <= (w_next_word == c_LAST_WORD);
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    mem_we_o   <= 1'b0;
                    row_done_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hd_memory_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hd_memory_write_ctrl
// Description : Self-checking bench for hd_memory_write_ctrl. A reference
//               model turns every accepted request into the list of memory
//               writes it must produce, one per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hd_memory_write_ctrl;
    import pkg_hd_memory::*;

    logic              clk = 1'b0;
    logic              rst_i;
    write_mode_t       cfg_mode_i;
    logic              row_valid_i, row_ready_o;
    logic [3:0]        row_addr_i;
    logic [511:0]      row_data_i;
    logic              host_valid_i, host_ready_o;
    logic [3:0]        host_row_i, host_word_i;
    logic [31:0]       host_data_i;
    logic              mem_we_o;
    write_mode_t       mem_mode_o;
    logic [3:0]        mem_row_o, mem_word_o;
    logic [511:0]      mem_wdata_o;
    logic              busy_o, row_done_o;

    hd_memory_write_ctrl #(.DIMENSION(512), .WORD_WIDTH(32), .NUM_ROWS(16)) dut (
        .clk_i(clk), .rst_i(rst_i), .cfg_mode_i(cfg_mode_i),
        .row_valid_i(row_valid_i), .row_ready_o(row_ready_o),
        .row_addr_i(row_addr_i), .row_data_i(row_data_i),
        .host_valid_i(host_valid_i), .host_ready_o(host_ready_o),
        .host_row_i(host_row_i), .host_word_i(host_word_i), .host_data_i(host_data_i),
        .mem_we_o(mem_we_o), .mem_mode_o(mem_mode_o), .mem_row_o(mem_row_o),
        .mem_word_o(mem_word_o), .mem_wdata_o(mem_wdata_o),
        .busy_o(busy_o), .row_done_o(row_done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         mode;   // 1 = row-wide write
        logic [3:0]   row;
        logic [3:0]   word;
        logic [511:0] data;
        logic         done;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    bit  last_host = 1'b1;    // encoder wins the first tie after reset
    bit  acc_row, acc_host;
    int  writes_seen = 0;
    int  cyc = 0;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Expected writes of one encoder row in the given mode.
    task automatic push_row(input logic [3:0] a, input logic [511:0] d, input logic m);
        wr_t e;
        if (m) begin
            e.mode = 1'b1; e.row = a; e.word = 4'd0; e.data = d; e.done = 1'b1;
            exp_q.push_back(e);
        end else begin
            for (int k = 0; k < 16; k++) begin
                e.mode = 1'b0; e.row = a; e.word = 4'(k);
                e.data = {480'd0, d[k*32 +: 32]};
                e.done = (k == 15);
                exp_q.push_back(e);
            end
        end
    endtask

    // One clock cycle: compare outputs with the model, then apply the
    // handshakes of this cycle to the model.
    task automatic cycle();
        wr_t e;
        bit  mbusy, er, eh;
        #1;
        mbusy = (exp_q.size() != 0);
        if (mem_we_o === 1'b1) writes_seen++;
        if (mbusy) begin
            e = exp_q.pop_front();
            chk("we", mem_we_o, 1'b1);
            chk("mode", mem_mode_o, e.mode);
            chk("row", mem_row_o, e.row);
            if (!e.mode) chk("word", mem_word_o, e.word);
            chk("wdata", mem_wdata_o, e.data);
            chk("row_done", row_done_o, e.done);
        end else begin
            chk("we_idle", mem_we_o, 1'b0);
            chk("done_idle", row_done_o, 1'b0);
        end
        chk("busy", busy_o, mbusy);
        er = !mbusy && row_valid_i && (!host_valid_i || last_host);
        eh = !mbusy && host_valid_i && (!row_valid_i || !last_host);
        acc_row = 1'b0; acc_host = 1'b0;
        if (!rst_i) begin
            chk("row_ready", row_ready_o, er);
            chk("host_ready", host_ready_o, eh);
            if (er) begin
                push_row(row_addr_i, row_data_i, cfg_mode_i == RowMode);
                last_host = 1'b0; acc_row = 1'b1;
            end else if (eh) begin
                e.mode = 1'b0; e.row = host_row_i; e.word = host_word_i;
                e.data = {480'd0, host_data_i}; e.done = 1'b0;
                exp_q.push_back(e);
                last_host = 1'b1; acc_host = 1'b1;
            end
        end else begin
            exp_q.delete();
            last_host = 1'b1;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain(input int maxc);
        int n = 0;
        while (exp_q.size() != 0 && n < maxc) begin cycle(); n++; end
        chk("drain_timeout", exp_q.size(), 0);
        cycle();
    endtask

    task automatic new_row();
        row_addr_i = 4'($urandom);
        row_data_i = rnd512();
    endtask

    task automatic new_host();
        host_row_i  = 4'($urandom);
        host_word_i = 4'($urandom);
        host_data_i = $urandom;
    endtask

    initial begin
        int g[3];
        int ng, n, t0, t1;
        rst_i = 1'b1; cfg_mode_i = WordMode;
        row_valid_i = 1'b0; host_valid_i = 1'b0;
        new_row(); new_host();
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        #1;
        // Reset state
        chk("rst_we", mem_we_o, 1'b0);
        chk("rst_mode", mem_mode_o, WordMode);
        chk("rst_row", mem_row_o, 4'd0);
        chk("rst_word", mem_word_o, 4'd0);
        chk("rst_wdata", mem_wdata_o, 512'd0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_done", row_done_o, 1'b0);
        chk("rst_rrdy", row_ready_o, 1'b0);
        chk("rst_hrdy", host_ready_o, 1'b0);
        @(negedge clk);

        // RowMode row 5, then a second row held valid to probe throughput
        cfg_mode_i = RowMode; row_addr_i = 4'd5;
        for (int k = 0; k < 16; k++) row_data_i[k*32 +: 32] = 32'hA5A5_0000 + 32'(k);
        row_valid_i = 1'b1;
        cycle();
        chk("rowmode_acc", acc_row, 1'b1);
        new_row();
        cycle();
        cycle();
        chk("rowmode_ready_2cyc", acc_row, 1'b1);
        row_valid_i = 1'b0;
        drain(4);

        // WordMode row 3
        cfg_mode_i = WordMode; row_addr_i = 4'd3;
        for (int k = 0; k < 16; k++) row_data_i[k*32 +: 32] = 32'h100 + 32'(k);
        row_valid_i = 1'b1;
        cycle();
        row_valid_i = 1'b0;
        drain(20);

        // Host request arriving mid-burst waits for the burst to end
        new_row(); row_valid_i = 1'b1;
        cycle();
        row_valid_i = 1'b0;
        repeat (3) cycle();
        host_row_i = 4'd2; host_word_i = 4'd7; host_data_i = 32'hDEAD_BEEF;
        host_valid_i = 1'b1;
        n = 0;
        do begin cycle(); n++; end while (!acc_host && n < 30);
        chk("host_after_burst", acc_host, 1'b1);
        chk("host_wait_cycles", n, 14);
        host_valid_i = 1'b0;
        drain(4);

        // Three ties in a row: encoder, host, encoder
        new_row(); new_host();
        row_valid_i = 1'b1; host_valid_i = 1'b1; cfg_mode_i = RowMode;
        ng = 0; n = 0;
        while (ng < 3 && n < 60) begin
            cycle(); n++;
            if (acc_row)  begin g[ng] = 0; ng++; new_row();  end
            if (acc_host) begin g[ng] = 1; ng++; new_host(); end
        end
        row_valid_i = 1'b0; host_valid_i = 1'b0;
        chk("tie_count", ng, 3);
        chk("tie_g0", g[0], 0);
        chk("tie_g1", g[1], 1);
        chk("tie_g2", g[2], 0);
        drain(20);

        // cfg_mode_i flipped to RowMode at word 4 of a burst
        cfg_mode_i = WordMode; new_row(); row_valid_i = 1'b1;
        cycle();
        new_row();
        repeat (4) cycle();
        cfg_mode_i = RowMode;
        n = 0;
        do begin cycle(); n++; end while (!acc_row && n < 30);
        chk("mode_change_acc", acc_row, 1'b1);
        row_valid_i = 1'b0;
        drain(4);

        // Reset at burst word 6, then a tie goes to the encoder
        cfg_mode_i = WordMode; new_row(); row_valid_i = 1'b1;
        cycle();
        row_valid_i = 1'b0;
        repeat (6) cycle();
        rst_i = 1'b1;
        cycle();
        rst_i = 1'b0;
        row_valid_i = 1'b1; host_valid_i = 1'b1; new_row(); new_host();
        cycle();
        chk("tie_after_rst", acc_row, 1'b1);
        row_valid_i = 1'b0; host_valid_i = 1'b0;
        drain(20);

        // Four back-to-back host writes with valid held
        writes_seen = 0; new_host(); host_valid_i = 1'b1;
        ng = 0; n = 0; t0 = 0;
        while (ng < 4 && n < 20) begin
            cycle(); n++;
            if (acc_host) begin
                if (ng > 0) chk("host_spacing", cyc - t0, 2);
                t0 = cyc; ng++; new_host();
                if (ng == 4) host_valid_i = 1'b0;
            end
        end
        host_valid_i = 1'b0;
        drain(4);
        chk("host_writes", writes_seen, 4);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            row_valid_i  = ($urandom_range(0, 2) != 0);
            host_valid_i = ($urandom_range(0, 2) != 0);
            cfg_mode_i   = ($urandom_range(0, 1) != 0) ? RowMode : WordMode;
            new_row(); new_host();
            cycle();
        end
        row_valid_i = 1'b0; host_valid_i = 1'b0;
        t1 = 0;
        drain(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
